mips_mem_arbiter: RTL and testbench

//  Shares the single-port unified MIPS memory between the CPU instruction-fetch port and data port.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mips_mem_arb_pick.sv | 31 +++
 rtl/mips_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types for the MIPS unified-memory arbiter
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESP   = 2'd2,
        HALTED = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        arb_src_t    src;
    } mem_cmd_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_mem_arb_pick.sv
// rtl/mips_mem_arb_pick.sv - winner selection; MEM_ARB_ROUND_ROBIN_EN selects round-robin over data priority
module mips_mem_arb_pick
    import mips_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       i_req,
    input  logic       d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  arb_src_t   last_src,
`else
    input  logic [3:0] starve_cnt,
`endif
    output arb_src_t   win_src
);

    always_comb begin
        win_src = SRC_DATA;
        if (i_req && !d_req) begin
            win_src = SRC_INSTR;
        end else if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_src = (last_src == SRC_DATA) ? SRC_INSTR : SRC_DATA;
`else
            // Data keeps priority until fetch has been passed over STARVE_LIMIT times in a row
            win_src = (starve_cnt == 4'(STARVE_LIMIT)) ? SRC_INSTR : SRC_DATA;
`endif
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares unified memory between fetch and data ports; MEM_ARB_ROUND_ROBIN_EN selects round-robin
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        halt_req,
    output logic        halted,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_active,
    output logic [31:0] mem_address,
    output logic        mem_wr_en,
    output logic        mem_read_en,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    arb_state_t state, state_next;
    mem_cmd_t   cmd;
    arb_src_t   win_src;
    logic       accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_src_t last_src;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_src <= SRC_DATA;
        end else if (accept) begin
            last_src <= win_src;
        end
    end

    mips_mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .i_req    (i_req),
        .d_req    (d_req),
        .last_src (last_src),
        .win_src  (win_src)
    );
`else
    logic [3:0] starve_cnt;

    // Counts consecutive data grants taken while a fetch was waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (!i_req) begin
            starve_cnt <= 4'd0;
        end else if (accept) begin
            if (win_src == SRC_INSTR) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    mips_mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt),
        .win_src    (win_src)
    );
`endif

    assign accept = ((state == IDLE) || (state == RESP)) && !halt_req && (i_req || d_req);
    assign i_gnt  = accept && (win_src == SRC_INSTR);
    assign d_gnt  = accept && (win_src == SRC_DATA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd        <= '0;
            mem_active <= 1'b1;
            halted     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (win_src == SRC_INSTR) begin
                    cmd <= '{addr: i_addr, we: 1'b0, be: 4'hF, wdata: 32'd0, src: SRC_INSTR};
                end else begin
                    cmd <= '{addr: d_addr, we: d_we, be: d_be, wdata: d_wdata, src: SRC_DATA};
                end
            end
            // Falling mem_active is the memory's cue to dump its contents
            if (state_next == HALTED) begin
                mem_active <= 1'b0;
                halted     <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        mem_address = 32'd0;
        mem_wr_en   = 1'b0;
        mem_read_en = 1'b0;
        mem_byte_en = 4'h0;
        mem_data_in = 32'd0;
        i_rvalid    = 1'b0;
        i_rdata     = 32'd0;
        d_rvalid    = 1'b0;
        d_rdata     = 32'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end else if (halt_req) begin
                    state_next = HALTED;
                end
            end
            ISSUE: begin
                state_next  = cmd.we ? IDLE : RESP;
                mem_address = cmd.addr;
                mem_wr_en   = cmd.we;
                mem_read_en = !cmd.we;
                mem_byte_en = cmd.we ? cmd.be : 4'hF;
                mem_data_in = cmd.we ? cmd.wdata : 32'd0;
            end
            RESP: begin
                if (accept) begin
                    state_next = ISSUE;
                end else if (halt_req) begin
                    state_next = HALTED;
                end else begin
                    state_next = IDLE;
                end
                if (cmd.src == SRC_INSTR) begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_data_out;
                end else begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_data_out;
                end
            end
            default: state_next = HALTED;
        endcase
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - directed bench for mips_mem_arbiter with a registered memory model
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        halt_req;
    logic        halted;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_active;
    logic [31:0] mem_address;
    logic        mem_wr_en;
    logic        mem_read_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:63];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        any_gnt;
    logic        any_strobe;
    logic        exp_i;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .halt_req     (halt_req),
        .halted       (halted),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_be         (d_be),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .mem_active   (mem_active),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_read_en  (mem_read_en),
        .mem_byte_en  (mem_byte_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always @(posedge clk) begin
        if (mem_read_en) begin
            mem_data_out <= mem[mem_address[7:2]];
        end
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_en[b]) begin
                    mem[mem_address[7:2]][8*b +: 8] <= mem_data_in[8*b +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h1000_0000 + k;
        mem[0]       = 32'h3C1D1000;
        mem_data_out = 32'd0;
        reset_n  = 1'b0;
        halt_req = 1'b0;
        i_req    = 1'b0;
        i_addr   = 32'd0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = 4'h0;
        d_addr   = 32'd0;
        d_wdata  = 32'd0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_active", {31'd0, mem_active}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_strobes", {30'd0, mem_read_en, mem_wr_en}, 32'd0);
        chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        tick();
        reset_n = 1'b1;

        // fetch from reset vector
        tick();
        i_req  = 1'b1;
        i_addr = 32'hBFC00000;
        @(negedge clk);
        chk("t1_i_gnt", {31'd0, i_gnt}, 32'd1);
        tick();
        i_req = 1'b0;
        @(negedge clk);
        chk("t1_read_en", {31'd0, mem_read_en}, 32'd1);
        chk("t1_address", mem_address, 32'hBFC00000);
        chk("t1_byte_en", {28'd0, mem_byte_en}, 32'hF);
        tick();
        @(negedge clk);
        chk("t1_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("t1_i_rdata", i_rdata, 32'h3C1D1000);

        // write then read back
        tick();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2_wr_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("t2_wr_en", {30'd0, mem_wr_en, mem_read_en}, 32'd2);
        chk("t2_wr_data", mem_data_in, 32'hDEADBEEF);
        chk("t2_wr_addr", mem_address, 32'h10);
        tick();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
        @(negedge clk);
        chk("t2_rd_gnt", {31'd0, d_gnt}, 32'd1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        chk("t2_rd_en", {31'd0, mem_read_en}, 32'd1);
        tick();
        @(negedge clk);
        chk("t2_d_rvalid", {30'd0, d_rvalid, i_rvalid}, 32'd2);
        chk("t2_d_rdata", d_rdata, 32'hDEADBEEF);

        // contention pattern
        tick();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        for (int g = 0; g < 10; g++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_i = (g % 2 == 0);
`else
            exp_i = (g % 5 == 4);
`endif
            @(negedge clk);
            chk($sformatf("t3_i_gnt_%0d", g), {31'd0, i_gnt}, {31'd0, exp_i});
            chk($sformatf("t3_d_gnt_%0d", g), {31'd0, d_gnt}, {31'd0, ~exp_i});
            tick();
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;

        // halt during ISSUE of a read
        tick();
        i_req = 1'b1; i_addr = 32'hBFC00000;
        @(negedge clk);
        chk("t4_i_gnt", {31'd0, i_gnt}, 32'd1);
        tick();
        i_req = 1'b0; halt_req = 1'b1;
        @(negedge clk);
        chk("t4_read_en", {31'd0, mem_read_en}, 32'd1);
        tick();
        i_req = 1'b1;
        @(negedge clk);
        chk("t4_i_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("t4_i_rdata", i_rdata, 32'h3C1D1000);
        chk("t4_active_resp", {31'd0, mem_active}, 32'd1);
        chk("t4_no_gnt_halt", {31'd0, i_gnt}, 32'd0);
        tick();
        @(negedge clk);
        chk("t4_active_low", {31'd0, mem_active}, 32'd0);
        chk("t4_halted", {31'd0, halted}, 32'd1);

        // requests while halted
        halt_req = 1'b0; d_req = 1'b1;
        any_gnt = 1'b0; any_strobe = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            any_gnt    = any_gnt | i_gnt | d_gnt;
            any_strobe = any_strobe | mem_read_en | mem_wr_en;
        end
        chk("t6_no_gnt", {31'd0, any_gnt}, 32'd0);
        chk("t6_no_strobe", {31'd0, any_strobe}, 32'd0);
        chk("t6_still_halted", {31'd0, halted}, 32'd0 + 32'd1);
        i_req = 1'b0; d_req = 1'b0;

        // reset mid-transaction
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        i_req = 1'b1; i_addr = 32'hBFC00000;
        @(negedge clk);
        chk("t5_i_gnt", {31'd0, i_gnt}, 32'd1);
        tick();
        i_req = 1'b0;
        @(negedge clk);
        chk("t5_read_en_pre", {31'd0, mem_read_en}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_read_en_drop", {31'd0, mem_read_en}, 32'd0);
        chk("t5_active", {31'd0, mem_active}, 32'd1);
        chk("t5_halted", {31'd0, halted}, 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5_no_rvalid", {31'd0, i_rvalid}, 32'd0);
        tick();
        i_req = 1'b1;
        @(negedge clk);
        chk("t5_idle_gnt", {31'd0, i_gnt}, 32'd1);
        chk("t5_no_rvalid2", {31'd0, i_rvalid}, 32'd0);
        tick();
        i_req = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
